signed_integrate_dump: RTL and testbench

//  Integrate-and-dump stage directly downstream of signed_adder. Consumes the adder's registered

---
 rtl/signed_integrate_dump_pkg.sv | 16 +
 rtl/signed_integrate_dump_vr_reg.sv | 45 ++++
 rtl/signed_integrate_dump.sv | 76 +++++++
 tb/tb_signed_integrate_dump.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/signed_integrate_dump_pkg.sv
// Shared sizing helpers for the integrate-and-dump stage.
package signed_integrate_dump_pkg;

  localparam int unsigned SID_IWIDTH_DEF = 17;
  localparam int unsigned SID_N_DEF      = 8;

  // Accumulating N samples grows the sum by clog2(N) bits, so it can never wrap.
  function automatic int unsigned sid_owidth(input int unsigned iw, input int unsigned n);
    return iw + $clog2(n);
  endfunction

  function automatic int unsigned sid_cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/signed_integrate_dump_vr_reg.sv
// Valid/ready output register: loads a new word, holds it until taken.
module signed_integrate_dump_vr_reg #(
  parameter int unsigned W = 19
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         ready_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A load only happens while ready_o is high, so a pending word is never overwritten.
  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/signed_integrate_dump.sv
// Integrate-and-dump: sums N accepted signed samples and emits one result per frame.
module signed_integrate_dump
  import signed_integrate_dump_pkg::*;
#(
  parameter int unsigned IWIDTH = SID_IWIDTH_DEF,
  parameter int unsigned N      = SID_N_DEF,
  localparam int unsigned OWIDTH = sid_owidth(IWIDTH, N),
  localparam int unsigned CW     = sid_cnt_width(N)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IWIDTH-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OWIDTH-1:0] o_data,
  output logic [CW-1:0]     o_cnt
);

  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [OWIDTH-1:0] acc_q, acc_d;
  logic signed [OWIDTH-1:0] sample_ext, sum;
  logic                     ready, accept, last, dump;

  assign sample_ext = OWIDTH'($signed(i_data));
  // The first sample of a frame restarts the sum, so no explicit clear of acc is needed on dump.
  assign sum        = (cnt_q == '0 ? '0 : acc_q) + sample_ext;
  assign last       = (cnt_q == CW'(N - 1));
  assign accept     = i_valid && ready && !i_clear;
  assign dump       = accept && last;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (i_clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  signed_integrate_dump_vr_reg #(
    .W(OWIDTH)
  ) u_out_reg (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (dump),
    .data_i  (sum),
    .ready_i (i_ready),
    .valid_o (o_valid),
    .data_o  (o_data),
    .ready_o (ready)
  );

  assign o_ready = ready;
  assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_signed_integrate_dump.sv
// Randomised and directed checks of signed_integrate_dump (N=4 and N=1) against a queue-based model.
module tb_signed_integrate_dump;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic [16:0] i_data = '0;

  logic        o_ready4, o_valid4, o_ready1, o_valid1;
  logic [18:0] o_data4;
  logic [2:0]  o_cnt4;
  logic [16:0] o_data1;
  logic [0:0]  o_cnt1;

  always #5 clk = ~clk;

  signed_integrate_dump #(.IWIDTH(17), .N(4)) dut4 (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready4),
    .i_data(i_data), .o_valid(o_valid4), .i_ready(i_ready), .o_data(o_data4), .o_cnt(o_cnt4)
  );

  signed_integrate_dump #(.IWIDTH(17), .N(1)) dut1 (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready1),
    .i_data(i_data), .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1), .o_cnt(o_cnt1)
  );

  int checks = 0;
  int errors = 0;

  // Reference: frame contents as a queue, output slot as valid flag plus value. Index 0 is N=4, 1 is N=1.
  int     q4[$];
  int     q1[$];
  bit     mv[2];
  longint md[2];

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q4.delete();
    q1.delete();
    mv[0] = 1'b0; mv[1] = 1'b0;
    md[0] = 0;    md[1] = 0;
  endtask

  task automatic model_step(input int k);
    int     frame[$];
    int     n;
    bit     rdy, dump;
    longint s;
    if (k == 0) begin frame = q4; n = 4; end
    else        begin frame = q1; n = 1; end
    rdy  = !mv[k] || i_ready;
    dump = 1'b0;
    s    = 0;
    if (i_clear) begin
      frame.delete();
    end else if (i_valid && rdy) begin
      frame.push_back(int'($signed(i_data)));
      if (frame.size() == n) begin
        foreach (frame[j]) s += frame[j];
        frame.delete();
        dump = 1'b1;
      end
    end
    if (dump) begin
      mv[k] = 1'b1;
      md[k] = s;
      $display("N=%0d dump sum=%0d", n, s);
    end else if (i_ready) begin
      mv[k] = 1'b0;
    end
    if (k == 0) q4 = frame;
    else        q1 = frame;
  endtask

  task automatic check_outputs();
    check("valid4", longint'(o_valid4), longint'(mv[0]));
    check("data4",  longint'($signed(o_data4)), md[0]);
    check("cnt4",   longint'(o_cnt4), longint'(q4.size()));
    check("valid1", longint'(o_valid1), longint'(mv[1]));
    check("data1",  longint'($signed(o_data1)), md[1]);
    check("cnt1",   longint'(o_cnt1), longint'(q1.size()));
  endtask

  // Called just after a falling edge: drive, check ready, clock, update model, check registers.
  task automatic tick(input bit v, input int d, input bit r, input bit c);
    i_valid = v;
    i_data  = 17'(d);
    i_ready = r;
    i_clear = c;
    #1;
    check("ready4", longint'(o_ready4), longint'(!mv[0] || r));
    check("ready1", longint'(o_ready1), longint'(!mv[1] || r));
    @(posedge clk);
    if (i_rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    #1;
    check_outputs();
  endtask

  task automatic async_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid4", longint'(o_valid4), 0);
    check("rst_data4",  longint'($signed(o_data4)), 0);
    check("rst_cnt4",   longint'(o_cnt4), 0);
    check("rst_valid1", longint'(o_valid1), 0);
    check("rst_data1",  longint'($signed(o_data1)), 0);
    @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    check("rst_ready4", longint'(o_ready4), 1);
  endtask

  initial begin
    @(negedge clk);
    #1;
    async_reset();

    // Simple frame and latency
    for (int i = 1; i <= 4; i++) tick(1'b1, i, 1'b1, 1'b0);
    check("t1_data", longint'($signed(o_data4)), 10);
    check("t1_valid", longint'(o_valid4), 1);
    tick(1'b0, 0, 1'b1, 1'b0);
    check("t1_drop", longint'(o_valid4), 0);

    // Extremes without wrap
    for (int i = 0; i < 4; i++) tick(1'b1, -65536, 1'b1, 1'b0);
    check("t2_min", longint'($signed(o_data4)), -262144);
    for (int i = 0; i < 4; i++) tick(1'b1, 65535, 1'b1, 1'b0);
    check("t2_max", longint'($signed(o_data4)), 262140);
    tick(1'b0, 0, 1'b1, 1'b0);

    // Backpressure: first dump holds, later offers stall
    for (int i = 0; i < 8; i++) tick(1'b1, 1, 1'b0, 1'b0);
    check("t3_data", longint'($signed(o_data4)), 4);
    check("t3_valid", longint'(o_valid4), 1);
    check("t3_stall", longint'(o_ready4), 0);
    check("t3_cnt", longint'(o_cnt4), 0);
    tick(1'b1, 1, 1'b1, 1'b0);
    check("t3_taken", longint'(o_valid4), 0);
    check("t3_cnt1", longint'(o_cnt4), 1);

    // Clear drops partial sum and the sample presented with it
    tick(1'b1, 5, 1'b1, 1'b0);
    tick(1'b1, 5, 1'b1, 1'b0);
    tick(1'b1, 7, 1'b1, 1'b1);
    check("t4_cnt", longint'(o_cnt4), 0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1, 1'b1, 1'b0);
    check("t4_data", longint'($signed(o_data4)), 4);

    // Async reset mid-frame
    tick(1'b1, 3, 1'b1, 1'b0);
    tick(1'b1, 3, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 2, 1'b1, 1'b0);
    check("t5_data", longint'($signed(o_data4)), 8);

    // N=1: register only, back-to-back
    tick(1'b1, -7, 1'b1, 1'b0);
    check("t6_a", longint'($signed(o_data1)), -7);
    tick(1'b1, 9, 1'b1, 1'b0);
    check("t6_b", longint'($signed(o_data1)), 9);
    check("t6_valid", longint'(o_valid1), 1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      int d;
      case ($urandom_range(0, 5))
        0:       d = -65536;
        1:       d = 65535;
        default: d = int'($urandom_range(0, 131071)) - 65536;
      endcase
      if ($urandom_range(0, 149) == 0) async_reset();
      tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
